dmem_tier_responder: RTL



---
 rtl/dmem_tier_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dmem_tier_responder.sv
// Memory-die responder for the byte-lane data-memory link: four DEPTH x 8 banks with a
// post-reset init sweep. Define DMEM_PARITY_EN to add per-byte even parity and parity_err.
module dmem_tier_responder #(
    parameter int          DEPTH    = 256,
    parameter logic [7:0]  INIT_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ce_mem,
    input  logic [3:0] we_mem,
    input  logic [7:0] dataadr,
    input  logic [7:0] writedata,
    output logic [7:0] inter_dmem0,
    output logic [7:0] inter_dmem1,
    output logic [7:0] inter_dmem2,
    output logic [7:0] inter_dmem3,
    output logic       init_busy,
    output logic       parity_err
);

    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [0:0]    ST_INIT   = 1'b0;
    localparam logic [0:0]    ST_SERVE  = 1'b1;

    logic [0:0]    state_r;
    logic [AW-1:0] init_cnt_r;
    logic [7:0]    mem [4][DEPTH];
    logic [7:0]    lane_r [4];
    logic [AW-1:0] addr_s;
    logic [AW-1:0] mem_addr_s;
    logic [3:0]    wr_en_s;
    logic [7:0]    wr_data_s;

    // Upper address bits alias onto the bank.
    assign addr_s = dataadr[AW-1:0];

    // Bank write port: sweep writes during INIT, lane writes during SERVE; never while in reset.
    always_comb begin
        wr_en_s    = 4'b0000;
        mem_addr_s = addr_s;
        wr_data_s  = writedata;
        if (state_r == ST_INIT) begin
            wr_en_s    = {4{reset}};
            mem_addr_s = init_cnt_r;
            wr_data_s  = INIT_VAL;
        end else begin
            wr_en_s    = ce_mem & we_mem & {4{reset}};
            mem_addr_s = addr_s;
            wr_data_s  = writedata;
        end
    end

    // Two-state controller with the sweep address counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {AW{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == LAST_ADDR) begin
                        state_r    <= ST_SERVE;
                        init_cnt_r <= {AW{1'b0}};
                    end else begin
                        state_r    <= ST_INIT;
                        init_cnt_r <= init_cnt_r + AW'(1);
                    end
                end
                ST_SERVE: begin
                    state_r    <= ST_SERVE;
                    init_cnt_r <= {AW{1'b0}};
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= {AW{1'b0}};
                end
            endcase
        end
    end

    // Bank storage; contents are rebuilt by the sweep rather than reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s[i]) begin
                mem[i][mem_addr_s] <= wr_data_s;
            end
        end
    end

    // Registered read lanes: read data or write-through, held while the lane is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                lane_r[i] <= 8'h00;
            end
        end else if (state_r == ST_INIT) begin
            for (int i = 0; i < 4; i++) begin
                lane_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ce_mem[i]) begin
                    lane_r[i] <= we_mem[i] ? writedata : mem[i][addr_s];
                end else begin
                    lane_r[i] <= lane_r[i];
                end
            end
        end
    end

    assign inter_dmem0 = lane_r[0];
    assign inter_dmem1 = lane_r[1];
    assign inter_dmem2 = lane_r[2];
    assign inter_dmem3 = lane_r[3];
    assign init_busy   = (state_r == ST_INIT);

`ifdef DMEM_PARITY_EN
    logic par_mem [4][DEPTH];
    logic perr_s;
    logic parity_err_r;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // Parity bit travels with every bank write, including the sweep.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s[i]) begin
                par_mem[i][mem_addr_s] <= even_par(wr_data_s);
            end
        end
    end

    // Only true reads are checked; write-through lanes never flag.
    always_comb begin
        perr_s = 1'b0;
        if (state_r == ST_SERVE) begin
            for (int i = 0; i < 4; i++) begin
                if (ce_mem[i] && !we_mem[i] &&
                    (even_par(mem[i][addr_s]) != par_mem[i][addr_s])) begin
                    perr_s = 1'b1;
                end else begin
                    perr_s = perr_s;
                end
            end
        end else begin
            perr_s = 1'b0;
        end
    end

    // Error flag aligned with the returned lane data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= perr_s;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule
